// File: rtl/micro_seq_if.sv
// Shared single-master memory bus between the micro-procedure sequencer
// (master) and the ROM/scratch target (slave). mem_data is bidirectional:
// the master drives it only while mem_we is high, the target drives read data otherwise.
interface micro_seq_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;

    modport master (
        output mem_we,
        output mem_addr,
        inout  mem_data
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        inout  mem_data
    );
endinterface

// File: rtl/micro_seq.sv
// Micro-procedure sequencer: fetches micro-instruction words from the
// procedure region and executes them against the scratch window until an
// END op, an illegal op or a step-limit overrun. Every bus output comes
// from a register, so the next-cycle bus values are computed ahead of time
// from the next state.
module micro_seq #(
    parameter int          MAX_STEPS = 4096,
    parameter logic [31:0] PRC_BASE  = 32'hffffe000,
    parameter logic [31:0] SCR_BASE  = 32'hffffc000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  entry,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  pc,
    micro_seq_if.master bus
);
    localparam int SW = $clog2(MAX_STEPS + 1);

    localparam logic [3:0] OP_END  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_BEQZ = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RDA   = 3'd2,
        ST_RDB   = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t          state_r, state_s;
    logic [9:0]      pc_r, pc_s;
    logic [3:0]      ir_op_r, ir_op_s;
    logic [7:0]      ir_a_r, ir_a_s;
    logic [7:0]      ir_b_r, ir_b_s;
    logic [9:0]      ir_tgt_r, ir_tgt_s;
    logic [31:0]     opa_r, opa_s;
    logic [31:0]     res_r, res_s;
    logic [SW-1:0]   step_r, step_s;
    logic            err_r, err_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            we_r, we_s;
    logic [31:0]     addr_r, addr_s;

    logic [31:0]     rdata_s;
    logic [3:0]      fop_s;
    logic            overrun_s;

    assign rdata_s   = bus.mem_data;
    assign fop_s     = rdata_s[31:28];
    assign overrun_s = (step_r == SW'(MAX_STEPS));

    // Result of a data op given the A operand and the B operand.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = b;
        endcase
        return r;
    endfunction

    // Byte address of a scratch word.
    function automatic logic [31:0] scr_addr_f(input logic [7:0] idx);
        return SCR_BASE + {22'd0, idx, 2'b00};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; FETCH branches on the opcode arriving on the bus.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_FETCH;
                else       state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (overrun_s) begin
                    state_s = ST_DONE;
                end else begin
                    case (fop_s)
                        OP_MOV:                                  state_s = ST_RDB;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:   state_s = ST_RDA;
                        OP_BEQZ:                                 state_s = ST_RDA;
                        OP_JMP:                                  state_s = ST_FETCH;
                        default:                                 state_s = ST_DONE;
                    endcase
                end
            end
            ST_RDA: begin
                if (ir_op_r == OP_BEQZ) state_s = ST_FETCH;
                else                    state_s = ST_RDB;
            end
            ST_RDB:  state_s = ST_WR;
            ST_WR:   state_s = ST_FETCH;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath updates and next-cycle bus/status values derived from the next state.
    always_comb begin
        pc_s     = pc_r;
        ir_op_s  = ir_op_r;
        ir_a_s   = ir_a_r;
        ir_b_s   = ir_b_r;
        ir_tgt_s = ir_tgt_r;
        opa_s    = opa_r;
        res_s    = res_r;
        step_s   = step_r;
        err_s    = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    pc_s   = entry;
                    step_s = '0;
                    err_s  = 1'b0;
                end else begin
                    pc_s   = pc_r;
                end
            end
            ST_FETCH: begin
                if (overrun_s) begin
                    err_s = 1'b1;
                end else begin
                    ir_op_s  = fop_s;
                    ir_a_s   = rdata_s[27:20];
                    ir_b_s   = rdata_s[19:12];
                    ir_tgt_s = rdata_s[9:0];
                    step_s   = step_r + SW'(1);
                    if (fop_s == OP_JMP) pc_s = rdata_s[9:0];
                    else                 pc_s = pc_r + 10'd1;
                    if (fop_s > OP_BEQZ) err_s = 1'b1;
                    else                 err_s = err_r;
                end
            end
            ST_RDA: begin
                opa_s = rdata_s;
                if ((ir_op_r == OP_BEQZ) && (rdata_s == 32'd0)) pc_s = ir_tgt_r;
                else                                            pc_s = pc_r;
            end
            ST_RDB: begin
                res_s = alu_f(ir_op_r, opa_r, rdata_s);
            end
            default: begin
                pc_s = pc_r;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
        we_s   = (state_s == ST_WR);
        case (state_s)
            ST_FETCH: addr_s = PRC_BASE + {20'd0, pc_s, 2'b00};
            ST_RDA:   addr_s = scr_addr_f(ir_a_s);
            ST_RDB:   addr_s = scr_addr_f(ir_b_s);
            ST_WR:    addr_s = scr_addr_f(ir_a_s);
            default:  addr_s = 32'd0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r     <= 10'd0;
            ir_op_r  <= 4'd0;
            ir_a_r   <= 8'd0;
            ir_b_r   <= 8'd0;
            ir_tgt_r <= 10'd0;
            opa_r    <= 32'd0;
            res_r    <= 32'd0;
            step_r   <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= 32'd0;
        end else begin
            pc_r     <= pc_s;
            ir_op_r  <= ir_op_s;
            ir_a_r   <= ir_a_s;
            ir_b_r   <= ir_b_s;
            ir_tgt_r <= ir_tgt_s;
            opa_r    <= opa_s;
            res_r    <= res_s;
            step_r   <= step_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            we_r     <= we_s;
            addr_r   <= addr_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign pc            = pc_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_data  = we_r ? res_r : 32'bz;
endmodule

// File: tb/tb_micro_seq.sv
// Bench for micro_seq: an instruction-level model predicts the per-cycle
// bus activity of each run and a compare process checks the DUT against it;
// literal checks pin the model. A second instance with MAX_STEPS=4 covers
// the step-limit abort.
module tb_micro_seq;
    localparam logic [31:0] PRC = 32'hffffe000;
    localparam logic [31:0] SCR = 32'hffffc000;

    typedef struct {
        logic        done;
        logic        err;
        logic        we;
        logic        ca;
        logic [31:0] addr;
        logic [31:0] data;
        logic [9:0]  pc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] entry = 10'd0;
    logic       busy, done, err;
    logic [9:0] pc;
    logic       start2 = 1'b0;
    logic       busy2, done2, err2;
    logic [9:0] pc2;

    micro_seq_if bus ();
    micro_seq_if bus2 ();

    micro_seq #(.MAX_STEPS(4096)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .entry(entry),
        .busy(busy), .done(done), .err(err), .pc(pc), .bus(bus)
    );

    micro_seq #(.MAX_STEPS(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .entry(10'd5),
        .busy(busy2), .done(done2), .err(err2), .pc(pc2), .bus(bus2)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] prc [0:1023];
    logic [31:0] scr [0:255];
    logic [31:0] msc [0:255];
    logic [31:0] wlog [$];
    exp_t        exp_q [$];
    logic        armed = 1'b0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_val = 32'd0;
    logic        rd_hit;
    logic [31:0] rd_val;
    logic        scr_hit;

    // Target: procedure ROM and scratch RAM, combinational reads.
    always_comb begin
        rd_hit  = 1'b0;
        rd_val  = 32'd0;
        scr_hit = (bus.mem_addr[31:10] == 22'h3ffff0);
        if (bus.mem_addr[31:12] == 20'hffffe) begin
            rd_hit = 1'b1;
            rd_val = prc[bus.mem_addr[11:2]];
        end else if (scr_hit) begin
            rd_hit = 1'b1;
            rd_val = scr[bus.mem_addr[9:2]];
        end else begin
            rd_hit = 1'b0;
        end
    end
    assign bus.mem_data  = (rd_hit && !bus.mem_we) ? rd_val : 32'bz;
    assign bus2.mem_data = (!bus2.mem_we && bus2.mem_addr[31:12] == 20'hffffe) ? 32'h7000_0005 : 32'bz;

    // Scratch writes commit at the closing edge; word 0 and constants discard.
    always @(posedge clk) begin
        if (pl_en) begin
            scr[pl_idx] <= pl_val;
        end else if (bus.mem_we && scr_hit) begin
            wlog.push_back(bus.mem_data);
            if (bus.mem_addr[9:2] != 8'd0 && !(bus.mem_addr[9:2] >= 8'd64 && bus.mem_addr[9:2] <= 8'd127))
                scr[bus.mem_addr[9:2]] <= bus.mem_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [9:0] t);
        return {op, a, b, 2'b00, t};
    endfunction

    task automatic push(input logic d, input logic e, input logic we, input logic ca,
                        input logic [31:0] ad, input logic [31:0] dt, input logic [9:0] p);
        exp_t x;
        x.done = d; x.err = e; x.we = we; x.ca = ca; x.addr = ad; x.data = dt; x.pc = p;
        exp_q.push_back(x);
    endtask

    // Instruction-level interpreter producing the expected cycle trace of one run.
    task automatic model_run(input logic [9:0] ent);
        logic [9:0]  mpc;
        logic [9:0]  npc;
        logic [31:0] w, va, vb, r;
        logic [3:0]  op;
        logic [7:0]  a, b;
        int          steps;
        bit          fin;
        mpc = ent; steps = 0; fin = 1'b0;
        while (!fin) begin
            push(1'b0, 1'b0, 1'b0, 1'b1, PRC + 32'(mpc) * 32'd4, 32'd0, 10'd0);
            if (steps == 4096) begin
                push(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, mpc);
                fin = 1'b1;
            end else begin
                steps++;
                w = prc[mpc]; op = w[31:28]; a = w[27:20]; b = w[19:12];
                npc = mpc + 10'd1;
                if (op == 4'd0 || op > 4'd8) begin
                    push(1'b1, op != 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, npc);
                    fin = 1'b1;
                end else if (op == 4'd7) begin
                    npc = w[9:0];
                end else if (op == 4'd8) begin
                    push(1'b0, 1'b0, 1'b0, 1'b1, SCR + 32'(a) * 32'd4, 32'd0, 10'd0);
                    if (msc[a] == 32'd0) npc = w[9:0];
                end else begin
                    va = msc[a]; vb = msc[b];
                    if (op != 4'd1) push(1'b0, 1'b0, 1'b0, 1'b1, SCR + 32'(a) * 32'd4, 32'd0, 10'd0);
                    push(1'b0, 1'b0, 1'b0, 1'b1, SCR + 32'(b) * 32'd4, 32'd0, 10'd0);
                    case (op)
                        4'd2:    r = va + vb;
                        4'd3:    r = va - vb;
                        4'd4:    r = va & vb;
                        4'd5:    r = va | vb;
                        4'd6:    r = va ^ vb;
                        default: r = vb;
                    endcase
                    push(1'b0, 1'b0, 1'b1, 1'b1, SCR + 32'(a) * 32'd4, r, 10'd0);
                    if (a != 8'd0 && !(a >= 8'd64 && a <= 8'd127)) msc[a] = r;
                end
                mpc = npc;
            end
        end
    endtask

    // Per-cycle comparison of the DUT against the model trace.
    always @(negedge clk) begin
        if (armed && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("busy", {31'd0, busy}, 32'd1);
            check("done", {31'd0, done}, {31'd0, e.done});
            check("err", {31'd0, err}, {31'd0, e.err});
            check("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
            if (e.ca) check("mem_addr", bus.mem_addr, e.addr);
            if (e.we) check("mem_data", bus.mem_data, e.data);
            if (e.done) check("pc_at_done", {22'd0, pc}, {22'd0, e.pc});
        end
    end

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx[7:0]; pl_val = v; msc[idx] = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run(input string name, input logic [9:0] ent, input int exp_len,
                       input bit ghost, input logic [9:0] gent);
        model_run(ent);
        check({name, "_model_len"}, 32'(exp_q.size()), 32'(exp_len));
        @(negedge clk);
        check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        entry = ent; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; entry = 10'h3ff; armed = 1'b1;
        if (ghost) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b1; entry = gent;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        armed = 1'b0;
    endtask

    initial begin
        int base;
        int cyc;
        for (int i = 0; i < 1024; i++) prc[i] = 32'd0;
        prc[16]  = enc(4'd1, 8'd1, 8'd67, 10'd0);
        prc[17]  = enc(4'd2, 8'd1, 8'd65, 10'd0);
        prc[18]  = enc(4'd0, 8'd0, 8'd0, 10'd0);
        prc[256] = enc(4'd8, 8'd32, 8'd0, 10'h103);
        prc[257] = enc(4'd3, 8'd32, 8'd64, 10'd0);
        prc[258] = enc(4'd7, 8'd0, 8'd0, 10'h100);
        prc[259] = enc(4'd0, 8'd0, 8'd0, 10'd0);
        prc[512] = 32'hc000_0000;

        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_pc", {22'd0, pc}, 32'd0);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        rst_n = 1'b1;

        preload(1, 32'd5);
        preload(65, 32'd2);
        preload(67, 32'd8);
        preload(32, 32'd3);
        preload(64, 32'd1);

        // MOV then ADD into R[1]
        base = wlog.size();
        run("movadd", 10'h010, 9, 1'b0, 10'd0);
        check("movadd_nwr", 32'(wlog.size() - base), 32'd2);
        if (wlog.size() - base == 2) begin
            check("movadd_w0", wlog[base], 32'd8);
            check("movadd_w1", wlog[base + 1], 32'd10);
        end
        check("movadd_r1", scr[1], 32'd10);

        // Countdown loop
        base = wlog.size();
        run("loop", 10'h100, 25, 1'b0, 10'd0);
        check("loop_nwr", 32'(wlog.size() - base), 32'd3);
        if (wlog.size() - base == 3) begin
            check("loop_w0", wlog[base], 32'd2);
            check("loop_w1", wlog[base + 1], 32'd1);
            check("loop_w2", wlog[base + 2], 32'd0);
        end
        check("loop_err", {31'd0, err}, 32'd0);

        // Illegal op at entry
        base = wlog.size();
        run("illegal", 10'h200, 2, 1'b0, 10'd0);
        check("illegal_err_held", {31'd0, err}, 32'd1);
        check("illegal_nwr", 32'(wlog.size() - base), 32'd0);

        // Start while busy is ignored; err clears on accepted start
        run("ghost", 10'h010, 9, 1'b1, 10'h200);
        check("ghost_err", {31'd0, err}, 32'd0);
        check("ghost_r1", scr[1], 32'd10);

        // Reset during WR
        preload(1, 32'd77);
        base = wlog.size();
        @(negedge clk);
        entry = 10'h010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20 && !bus.mem_we; k++) begin
            @(posedge clk); #1;
        end
        check("rstwr_saw_we", {31'd0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstwr_we", {31'd0, bus.mem_we}, 32'd0);
        check("rstwr_busy", {31'd0, busy}, 32'd0);
        check("rstwr_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstwr_busy_after", {31'd0, busy}, 32'd0);
        check("rstwr_r1", scr[1], 32'd77);
        check("rstwr_nwr", 32'(wlog.size() - base), 32'd0);

        // Step limit on the MAX_STEPS=4 instance, JMP self at 5
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            cyc++;
            if (done2) break;
        end
        check("steps_done_cycle", 32'(cyc), 32'd6);
        check("steps_done", {31'd0, done2}, 32'd1);
        check("steps_err", {31'd0, err2}, 32'd1);
        check("steps_pc", {22'd0, pc2}, 32'd5);
        @(negedge clk);
        check("steps_done_pulse", {31'd0, done2}, 32'd0);
        check("steps_err_held", {31'd0, err2}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
